// File: rtl/regfile_loader_if.sv
// Bundle between regfile_loader and its environment:
// control, load/dump streams and register-file ports.
interface regfile_loader_if #(
  parameter int addr_width = 5,
  parameter int data_width = 32
);
  logic                  start;
  logic [1:0]            mode;
  logic [data_width-1:0] fill_data;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  in_valid;
  logic [data_width-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [data_width-1:0] out_data;
  logic                  out_ready;
  logic [addr_width-1:0] rf_addr_in;
  logic [data_width-1:0] rf_d_in;
  logic                  rf_we;
  logic [addr_width-1:0] rf_addr_rd;
  logic [data_width-1:0] rf_d_rd;

  modport master (
    input  start, mode, fill_data, abort,
    input  in_valid, in_data, out_ready,
    input  rf_d_rd,
    output busy, done, in_ready,
    output out_valid, out_data,
    output rf_addr_in, rf_d_in, rf_we,
    output rf_addr_rd
  );

  modport slave (
    output start, mode, fill_data, abort,
    output in_valid, in_data, out_ready,
    output rf_d_rd,
    input  busy, done, in_ready,
    input  out_valid, out_data,
    input  rf_addr_in, rf_d_in, rf_we,
    input  rf_addr_rd
  );
endinterface

// File: rtl/regfile_loader.sv
// Bulk fill / stream-load / stream-dump engine for a register file.
// Ports: CLK, RST (async, active-high); bus = regfile_loader_if.master
//   control: start, mode, fill_data, abort -> busy, done
//   load stream: in_valid, in_data -> in_ready
//   dump stream: out_ready -> out_valid, out_data (registered)
//   rf: rf_addr_in, rf_d_in, rf_we (write), rf_addr_rd -> rf_d_rd (read)
module regfile_loader #(
  parameter int addr_width = 5,
  parameter int data_width = 32,
  parameter int lo         = 0,
  parameter int hi         = 31
) (
  input  logic                CLK,
  input  logic                RST,
  regfile_loader_if.master    bus
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LOAD,
    DUMP,
    FIN
  } state_e;

  localparam logic [addr_width-1:0] LO =
    addr_width'(lo);
  localparam logic [addr_width-1:0] HI =
    addr_width'(hi);
  localparam logic [addr_width-1:0] ONE =
    addr_width'(1);

  state_e                state_q, state_d;
  logic [addr_width-1:0] ptr_q, ptr_d;
  logic [data_width-1:0] fill_q, fill_d;
  logic                  ov_q, ov_d;
  logic [data_width-1:0] od_q, od_d;
  // set once the hi entry has been captured
  // into the output register during DUMP
  logic                  exh_q, exh_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= LO;
      fill_q  <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      exh_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      fill_q  <= fill_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      exh_q   <= exh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    fill_d  = fill_q;
    ov_d    = ov_q;
    od_d    = od_q;
    exh_d   = exh_q;

    bus.busy       = (state_q == FILL) ||
                     (state_q == LOAD) ||
                     (state_q == DUMP);
    bus.done       = (state_q == FIN);
    bus.in_ready   = 1'b0;
    bus.rf_we      = 1'b0;
    bus.rf_d_in    = fill_q;
    bus.rf_addr_in = ptr_q;
    bus.rf_addr_rd = ptr_q;
    bus.out_valid  = ov_q;
    bus.out_data   = od_q;

    if (bus.abort && state_q != IDLE) begin
      // abort wins: no write, no handshake,
      // no DONE, back to a clean idle
      state_d = IDLE;
      ptr_d   = LO;
      ov_d    = 1'b0;
      exh_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            unique case (1'b1)
              (bus.mode == 2'b00): begin
                state_d = FILL;
                ptr_d   = LO;
                fill_d  = bus.fill_data;
              end
              (bus.mode == 2'b01): begin
                state_d = LOAD;
                ptr_d   = LO;
              end
              (bus.mode == 2'b10): begin
                state_d = DUMP;
                ptr_d   = LO;
                exh_d   = 1'b0;
              end
              default: ;
            endcase
          end
        end
        FILL: begin
          bus.rf_we = 1'b1;
          if (ptr_q == HI) state_d = FIN;
          else ptr_d = ptr_q + ONE;
        end
        LOAD: begin
          bus.in_ready = 1'b1;
          bus.rf_d_in  = bus.in_data;
          bus.rf_we    = bus.in_valid;
          if (bus.in_valid) begin
            if (ptr_q == HI) state_d = FIN;
            else ptr_d = ptr_q + ONE;
          end
        end
        DUMP: begin
          if (!exh_q &&
              (!ov_q || bus.out_ready)) begin
            od_d = bus.rf_d_rd;
            ov_d = 1'b1;
            if (ptr_q == HI) exh_d = 1'b1;
            else ptr_d = ptr_q + ONE;
          end else if (ov_q && bus.out_ready) begin
            // once exhausted, the word leaving
            // now is the hi entry
            ov_d = 1'b0;
            if (exh_q) state_d = FIN;
          end
        end
        FIN: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_loader.sv
// Self-checking bench for regfile_loader:
// mode decode table plus directed fill/load/dump/abort/reset runs.
module tb_regfile_loader;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_loader_if #(
    .addr_width(AW),
    .data_width(DW)
  ) bus ();

  regfile_loader #(
    .addr_width(AW),
    .data_width(DW),
    .lo(0),
    .hi(N-1)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  // register file: one write port, one comb read port
  logic [DW-1:0] rf [N];
  logic [1:0]    ld_op = 2'd0;
  always @(posedge clk) begin
    if (ld_op == 2'd1)
      for (int i = 0; i < N; i++) rf[i] <= '0;
    else if (ld_op == 2'd2)
      for (int i = 0; i < N; i++) rf[i] <= DW'(i * 3);
    else if (bus.rf_we)
      rf[bus.rf_addr_in] <= bus.rf_d_in;
  end
  assign bus.rf_d_rd = rf[bus.rf_addr_rd];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [1:0] op);
    ld_op = op;
    step;
    ld_op = 2'd0;
  endtask

  task automatic run_fill(input logic [DW-1:0] val,
                          input logic hold,
                          output int wr,
                          output int errs,
                          output int dcyc,
                          output int irdy);
    wr = 0; errs = 0; dcyc = 0; irdy = 0;
    step;
    bus.start = 1'b1;
    bus.mode = 2'b00;
    bus.fill_data = val;
    step;
    // value must have been captured at accept;
    // a held START must be ignored while busy
    bus.start = hold;
    bus.mode = hold ? 2'b01 : 2'b00;
    bus.fill_data = ~val;
    for (int c = 2; c < 200; c++) begin
      @(negedge clk);
      if (bus.in_ready) irdy++;
      if (bus.rf_we) begin
        if (bus.rf_addr_in != AW'(wr) ||
            bus.rf_d_in != val) errs++;
        wr++;
      end
      if (bus.done) begin
        dcyc = c;
        break;
      end
      step;
    end
    bus.start = 1'b0;
    bus.mode = 2'b00;
  endtask

  typedef struct {
    logic       start;
    logic [1:0] mode;
    logic       busy;
    logic       in_ready;
    logic       we;
  } vec_t;

  vec_t tbl [6];

  int wr, errs, dcyc, irdy, beats, dcnt, nw;
  int stall, nstall, nv, gaps, first, last, cnt;
  logic           pv, pr;
  logic [DW-1:0]  pd;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 2'b10, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0};

    bus.start = 1'b0;
    bus.mode = 2'b00;
    bus.fill_data = '0;
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst in_ready", bus.in_ready, 0);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst out_data", bus.out_data, 0);
    chk("rst rf_we", bus.rf_we, 0);
    chk("rst ptr", bus.rf_addr_in, 0);
    rst = 1'b0;
    step;

    // mode decode table, each leg aborted back to idle
    for (int i = 0; i < 6; i++) begin
      step;
      bus.start = tbl[i].start;
      bus.mode = tbl[i].mode;
      step;
      bus.start = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d busy", i),
          bus.busy, tbl[i].busy);
      chk($sformatf("tbl%0d in_ready", i),
          bus.in_ready, tbl[i].in_ready);
      chk($sformatf("tbl%0d rf_we", i),
          bus.rf_we, tbl[i].we);
      step;
      bus.abort = 1'b1;
      @(negedge clk);
      chk($sformatf("tbl%0d abort we", i),
          bus.rf_we, 0);
      chk($sformatf("tbl%0d abort rdy", i),
          bus.in_ready, 0);
      step;
      bus.abort = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d idle busy", i),
          bus.busy, 0);
      chk($sformatf("tbl%0d no done", i),
          bus.done, 0);
    end

    // FILL 0xDEADBEEF
    run_fill(32'hDEADBEEF, 1'b0, wr, errs, dcyc, irdy);
    chk("fill writes", wr, 32);
    chk("fill addr/data", errs, 0);
    chk("fill done cycle", dcyc, 34);
    step;
    cnt = 0;
    for (int i = 0; i < N; i++)
      if (rf[i] !== 32'hDEADBEEF) cnt++;
    chk("fill contents", cnt, 0);
    chk("fill idle busy", bus.busy, 0);

    // LOAD with random IN_VALID gaps
    preload(2'd1);
    step;
    bus.start = 1'b1;
    bus.mode = 2'b01;
    step;
    bus.start = 1'b0;
    beats = 0; dcnt = 0; errs = 0;
    for (int c = 0; c < 400; c++) begin
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_data = 32'h100 + DW'(beats);
      @(negedge clk);
      if (bus.rf_we !==
          (bus.in_valid && bus.in_ready)) errs++;
      if (bus.rf_we) begin
        if (bus.rf_addr_in != AW'(beats)) errs++;
        beats++;
      end
      if (bus.done) begin
        dcnt++;
        break;
      end
      step;
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step;
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("load beats", beats, 32);
    chk("load we/addr", errs, 0);
    chk("load done count", dcnt, 1);
    cnt = 0;
    for (int i = 0; i < N; i++)
      if (rf[i] !== 32'h100 + DW'(i)) cnt++;
    chk("load contents", cnt, 0);

    // DUMP with 3-cycle OUT_READY stalls
    step;
    preload(2'd2);
    bus.start = 1'b1;
    bus.mode = 2'b10;
    step;
    bus.start = 1'b0;
    nw = 0; errs = 0; stall = 0; nstall = 0;
    dcnt = 0; pv = 1'b0; pr = 1'b0; pd = '0;
    for (int c = 0; c < 600; c++) begin
      if (stall > 0) begin
        bus.out_ready = 1'b0;
        stall--;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.out_ready = 1'b0;
        stall = 2;
      end else begin
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
      if (pv && !pr) begin
        nstall++;
        if (!bus.out_valid ||
            bus.out_data !== pd) errs++;
      end
      if (bus.rf_we) errs++;
      if (bus.out_valid && bus.out_ready) begin
        if (bus.out_data !== DW'(nw * 3)) errs++;
        nw++;
      end
      pv = bus.out_valid;
      pr = bus.out_ready;
      pd = bus.out_data;
      if (bus.done) begin
        dcnt = 1;
        break;
      end
      step;
    end
    bus.out_ready = 1'b0;
    chk("dump stall words", nw, 32);
    chk("dump stall errs", errs, 0);
    chk("dump stall done", dcnt, 1);
    chk("dump stall hit", nstall > 0, 1);

    // DUMP at full throughput
    step;
    bus.start = 1'b1;
    bus.mode = 2'b10;
    bus.out_ready = 1'b1;
    step;
    bus.start = 1'b0;
    nv = 0; gaps = 0; first = -1; last = -1;
    dcyc = 0; errs = 0;
    for (int c = 2; c < 200; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (first < 0) first = c;
        else if (last != c - 1) gaps++;
        last = c;
        if (bus.out_data !== DW'(nv * 3)) errs++;
        nv++;
      end
      if (bus.done) begin
        dcyc = c;
        break;
      end
      step;
    end
    bus.out_ready = 1'b0;
    chk("dump full words", nv, 32);
    chk("dump full gaps", gaps, 0);
    chk("dump full data", errs, 0);
    chk("dump full done", dcyc, last + 1);

    // ABORT during LOAD after 10 beats
    step;
    preload(2'd1);
    bus.start = 1'b1;
    bus.mode = 2'b01;
    step;
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    beats = 0;
    for (int c = 0; c < 100; c++) begin
      bus.in_data = 32'h200 + DW'(beats);
      @(negedge clk);
      if (bus.rf_we) beats++;
      if (beats == 10) break;
      step;
    end
    step;
    bus.abort = 1'b1;
    bus.in_data = 32'h200 + DW'(beats);
    @(negedge clk);
    chk("abort we", bus.rf_we, 0);
    chk("abort in_ready", bus.in_ready, 0);
    step;
    bus.abort = 1'b0;
    cnt = 0; dcnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.rf_we || bus.busy) cnt++;
      if (bus.done) dcnt++;
      step;
    end
    bus.in_valid = 1'b0;
    chk("abort quiet", cnt, 0);
    chk("abort no done", dcnt, 0);
    chk("abort ptr lo", bus.rf_addr_in, 0);
    cnt = 0;
    for (int i = 0; i < N; i++)
      if (rf[i] !== ((i < 10) ?
          32'h200 + DW'(i) : 32'h0)) cnt++;
    chk("abort contents", cnt, 0);
    run_fill(32'h5A5A5A5A, 1'b0, wr, errs, dcyc, irdy);
    chk("refill writes", wr, 32);
    chk("refill done", dcyc, 34);
    step;
    chk("refill last", rf[N-1], 32'h5A5A5A5A);

    // MODE 11 ignored
    step;
    bus.start = 1'b1;
    bus.mode = 2'b11;
    step;
    bus.start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.busy || bus.done || bus.rf_we) cnt++;
      step;
    end
    chk("mode11 ignored", cnt, 0);

    // START held while busy
    run_fill(32'h11, 1'b1, wr, errs, dcyc, irdy);
    chk("busy start writes", wr, 32);
    chk("busy start data", errs, 0);
    chk("busy start rdy", irdy, 0);
    chk("busy start done", dcyc, 34);

    // RST mid-FILL
    step;
    preload(2'd1);
    bus.start = 1'b1;
    bus.mode = 2'b00;
    bus.fill_data = 32'h77;
    step;
    bus.start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.rf_we && bus.rf_addr_in == 5'd7) begin
        cnt = 1;
        break;
      end
      step;
    end
    chk("rst reach addr7", cnt, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst mid busy", bus.busy, 0);
    chk("rst mid we", bus.rf_we, 0);
    chk("rst mid done", bus.done, 0);
    chk("rst mid ptr", bus.rf_addr_in, 0);
    step;
    chk("rst no write", rf[7], 0);
    chk("rst kept write", rf[6], 32'h77);
    @(negedge clk);
    rst = 1'b0;
    step;
    @(negedge clk);
    chk("post rst idle", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
